// File: rtl/delta_sample_decoder.sv
// Streaming sign/magnitude delta decoder: a seed token is followed by FRAME_LEN deltas,
// and the samples are rebuilt by accumulation. Define DELTA_SAMPLE_DECODER_SAT_EN to clamp out-of-range sums instead of wrapping.
module delta_sample_decoder #(
  parameter int W         = 6,
  parameter int FRAME_LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_seed,
  input  logic         in_sign,
  input  logic [W-1:0] in_mag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sample,
  output logic         out_last,
  output logic         ovf,
  output logic         proto_err
);

  typedef enum logic {WAIT_SEED, RUN} state_e;

  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

  state_e       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_sample_q, out_sample_d;
  logic         out_last_q, out_last_d;
  logic         ovf_q, ovf_d;
  logic         proto_err_q, proto_err_d;

  logic         accept;
  logic [W+1:0] sum;
  logic         oor;
  logic [W-1:0] res;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_last   = out_last_q;
  assign ovf        = ovf_q;
  assign proto_err  = proto_err_q;

  // Two guard bits: the top bit marks a negative sum, and the next bit marks a sum above 2^W-1.
  always_comb begin
    sum = in_sign ? ({2'b00, acc_q} - {2'b00, in_mag})
                  : ({2'b00, acc_q} + {2'b00, in_mag});
    oor = |sum[W+1:W];
`ifdef DELTA_SAMPLE_DECODER_SAT_EN
    if (!oor)         res = sum[W-1:0];
    else if (sum[W+1]) res = '0;
    else              res = '1;
`else
    res = sum[W-1:0];
`endif
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_sample_d = out_sample_q;
    out_last_d   = out_last_q;
    ovf_d        = ovf_q;
    proto_err_d  = proto_err_q;
    if (accept) begin
      if (in_seed) begin
        // A seed arriving mid-frame aborts that frame and starts a new one.
        if (state_q == RUN) proto_err_d = 1'b1;
        acc_d        = in_mag;
        cnt_d        = '0;
        out_valid_d  = 1'b1;
        out_sample_d = in_mag;
        out_last_d   = 1'b0;
        state_d      = RUN;
      end else if (state_q == WAIT_SEED) begin
        proto_err_d = 1'b1;
      end else begin
        if (oor) ovf_d = 1'b1;
        acc_d        = res;
        out_valid_d  = 1'b1;
        out_sample_d = res;
        cnt_d        = cnt_q + 8'd1;
        out_last_d   = (cnt_q == LAST_CNT);
        if (cnt_q == LAST_CNT) state_d = WAIT_SEED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_SEED;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_last_q   <= 1'b0;
      ovf_q        <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      out_last_q   <= out_last_d;
      ovf_q        <= ovf_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_delta_sample_decoder.sv
// Bench for delta_sample_decoder: directed scenarios plus random traffic, checked against an integer reference model.
module tb_delta_sample_decoder;
  localparam int W = 6, FL = 4, MAXV = (1 << W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_seed = 1'b0, in_sign = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_mag = '0;
  logic in_ready, out_valid, out_last, ovf, proto_err;
  logic [W-1:0] out_sample;

  delta_sample_decoder #(.W(W), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_seed(in_seed), .in_sign(in_sign), .in_mag(in_mag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_last(out_last), .ovf(ovf), .proto_err(proto_err));

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  // Reference model: a queue of pending output samples, with {sample, last} stored as sample + 1000*last.
  int exp_q[$];
  int got[$];
  bit m_frame, m_ovf, m_perr;
  int m_acc, m_cnt;

  task automatic chk(input string tag, input int obs, input int expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic void model_tok(input bit sd, input bit sg, input int mg);
    int s;
    if (sd) begin
      if (m_frame) m_perr = 1;
      m_acc = mg; m_cnt = 0; m_frame = 1;
      exp_q.push_back(mg);
    end else if (!m_frame) begin
      m_perr = 1;
    end else begin
      s = sg ? m_acc - mg : m_acc + mg;
      if (s < 0 || s > MAXV) begin
        m_ovf = 1;
`ifdef DELTA_SAMPLE_DECODER_SAT_EN
        s = (s < 0) ? 0 : MAXV;
`else
        s = s & MAXV;
`endif
      end
      m_acc = s; m_cnt++;
      if (m_cnt == FL) m_frame = 0;
      exp_q.push_back(s + ((m_cnt == FL) ? 1000 : 0));
    end
  endfunction

  task automatic observe();
    chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_sample", int'(out_sample), exp_q[0] % 1000);
      chk("out_last", int'(out_last), int'(exp_q[0] >= 1000));
    end
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("proto_err", int'(proto_err), int'(m_perr));
  endtask

  // Drives one cycle of inputs (called just after a negedge), then checks the result at the next negedge.
  task automatic cyc(input bit v, input bit sd, input bit sg, input int mg, input bit ordy);
    bit acc_now;
    in_valid = v; in_seed = sd; in_sign = sg; in_mag = W'(mg); out_ready = ordy;
    #1;
    chk("in_ready", int'(in_ready), int'(exp_q.size() == 0 || ordy));
    acc_now = v && in_ready;
    if (exp_q.size() != 0 && ordy) got.push_back(exp_q.pop_front() % 1000);
    if (acc_now) model_tok(sd, sg, mg);
    @(negedge clk);
    in_valid = 1'b0;
    observe();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); got.delete();
    m_frame = 0; m_ovf = 0; m_perr = 0; m_acc = 0; m_cnt = 0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_flags", int'({ovf, proto_err}), 0);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Basic frame: seed 10, then +5, -3, +0, -12.
    cyc(1,1,0,10,1); cyc(1,0,0,5,1); cyc(1,0,1,3,1); cyc(1,0,0,0,1); cyc(1,0,1,12,1);
    chk("basic_last_flag", int'(out_last), 1);
    cyc(0,0,0,0,1);
    chk("basic_n", got.size(), 5);
    if (got.size() == 5) begin
      chk("basic_s0", got[0], 10); chk("basic_s1", got[1], 15); chk("basic_s2", got[2], 12);
      chk("basic_s3", got[3], 12); chk("basic_s4", got[4], 0);
    end
    chk("basic_flags", int'({ovf, proto_err}), 0);

    // Overflow, then underflow in a following frame; ovf must stay set.
    do_reset();
    cyc(1,1,0,60,1); cyc(1,0,0,10,1);
`ifdef DELTA_SAMPLE_DECODER_SAT_EN
    chk("ovf_sample", int'(out_sample), 63);
`else
    chk("ovf_sample", int'(out_sample), 6);
`endif
    chk("ovf_set", int'(ovf), 1);
    cyc(1,0,0,0,1); cyc(1,0,0,0,1); cyc(1,0,0,0,1);
    cyc(1,1,0,2,1); cyc(1,0,1,5,1);
`ifdef DELTA_SAMPLE_DECODER_SAT_EN
    chk("udf_sample", int'(out_sample), 0);
`else
    chk("udf_sample", int'(out_sample), 61);
`endif
    chk("ovf_sticky", int'(ovf), 1);

    // Backpressure: the seed of 7 is held for three cycles while a delta waits at the input.
    do_reset();
    cyc(1,1,0,7,1);
    for (int i = 0; i < 3; i++) begin
      cyc(1,0,0,1,0);
      chk("bp_hold", int'(out_sample), 7);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    cyc(1,0,0,1,1); cyc(1,0,0,1,1); cyc(1,0,0,1,1); cyc(1,0,0,1,1); cyc(0,0,0,0,1);
    chk("bp_n", got.size(), 5);
    if (got.size() == 5) chk("bp_last", got[4], 11);

    // Protocol errors: a delta while waiting for a seed, then a seed in mid-frame.
    do_reset();
    cyc(1,0,0,4,1);
    chk("perr_drop_valid", int'(out_valid), 0);
    chk("perr_set", int'(proto_err), 1);
    cyc(1,1,0,5,1); cyc(1,0,0,1,1); cyc(1,1,0,20,1);
    chk("perr_seed_sample", int'(out_sample), 20);
    for (int i = 0; i < FL; i++) begin
      cyc(1,0,0,1,1);
      chk("perr_last_pos", int'(out_last), int'(i == FL - 1));
    end

    // Reset while an output is pending, then a new seed of 33.
    cyc(1,1,0,9,0); cyc(0,0,0,0,0);
    do_reset();
    cyc(1,1,0,33,1);
    chk("post_rst_seed", int'(out_sample), 33);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0,3) != 0, $urandom_range(0,6) == 0, 1'($urandom),
               ($urandom_range(0,1) != 0) ? $urandom_range(0,8) : $urandom_range(0,MAXV),
               $urandom_range(0,3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
